mem_request_buffer: RTL and testbench

MEM_REQUEST_BUFFER -- requirements
Module: mem_request_buffer

---
 rtl/mem_request_buffer.sv | 158 +++++++++++++++
 tb/tb_mem_request_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_buffer.sv
// Request FIFO between main_memory_interface and main_memory: issues one request at a time and waits for the matching response.
// Optional statistics counters are compiled in when MEM_REQ_BUF_STATS_EN is defined.
module mem_request_buffer #(
    parameter int DATA_WIDTH                 = 32,
    parameter int ADDRESS_WIDTH              = 32,
    parameter int MSG_BITS                   = 4,
    parameter int DEPTH                      = 4,
    parameter int TIMEOUT                    = 1024,
    parameter logic [MSG_BITS-1:0] NO_REQ    = MSG_BITS'(0),
    parameter logic [MSG_BITS-1:0] R_REQ     = MSG_BITS'(1),
    parameter logic [MSG_BITS-1:0] WB_REQ    = MSG_BITS'(2),
    parameter logic [MSG_BITS-1:0] MEM_RESP  = MSG_BITS'(3)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MSG_BITS-1:0]      in_msg,
    input  logic [ADDRESS_WIDTH-1:0] in_address,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic [MSG_BITS-1:0]      resp_msg,
    output logic [ADDRESS_WIDTH-1:0] resp_address,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [MSG_BITS-1:0]      mem_msg,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data,
    input  logic [MSG_BITS-1:0]      mem_resp_msg,
    input  logic [ADDRESS_WIDTH-1:0] mem_resp_address,
    input  logic [DATA_WIDTH-1:0]    mem_resp_data,
    output logic                     error
`ifdef MEM_REQ_BUF_STATS_EN
    ,
    output logic [31:0]              stat_reads,
    output logic [31:0]              stat_writes,
    output logic [31:0]              stat_full_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERROR} state_t;

    state_t                   state_q;
    logic [TW-1:0]            wait_cnt_q;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [MSG_BITS-1:0]      fifo_msg_q  [DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_q [DEPTH];
    logic                     is_req, push, pop, issue, resp_match;

    assign in_ready   = (count_q < DEPTH_C);
    assign is_req     = (in_msg == R_REQ) || (in_msg == WB_REQ);
    assign push       = in_ready && is_req;
    assign issue      = (state_q == IDLE) && (count_q != '0);
    assign resp_match = (state_q == WAIT) && (mem_resp_msg == MEM_RESP) &&
                        (mem_resp_address == mem_address);
    // The head stays queued while outstanding and is only popped on its response.
    assign pop        = resp_match;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_msg_q[wr_ptr_q]  <= in_msg;
            fifo_addr_q[wr_ptr_q] <= in_address;
            fifo_data_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            mem_msg      <= NO_REQ;
            mem_address  <= '0;
            mem_data     <= '0;
            resp_msg     <= NO_REQ;
            resp_address <= '0;
            resp_data    <= '0;
            error        <= 1'b0;
        end else begin
            resp_msg <= NO_REQ;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        mem_msg     <= fifo_msg_q[rd_ptr_q];
                        mem_address <= fifo_addr_q[rd_ptr_q];
                        mem_data    <= fifo_data_q[rd_ptr_q];
                        wait_cnt_q  <= '0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_match) begin
                        mem_msg      <= NO_REQ;
                        resp_msg     <= MEM_RESP;
                        resp_address <= mem_address;
                        resp_data    <= (mem_msg == R_REQ) ? mem_resp_data : mem_data;
                        state_q      <= IDLE;
                    end else if (wait_cnt_q == TLAST) begin
                        error   <= 1'b1;
                        mem_msg <= NO_REQ;
                        state_q <= ERROR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
                end
                default: begin
                    // ERROR holds until reset; the FIFO may still fill.
                end
            endcase
        end
    end

`ifdef MEM_REQ_BUF_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_reads       <= '0;
            stat_writes      <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (issue && (fifo_msg_q[rd_ptr_q] == R_REQ))  stat_reads  <= sat_inc(stat_reads);
            if (issue && (fifo_msg_q[rd_ptr_q] == WB_REQ)) stat_writes <= sat_inc(stat_writes);
            if (!in_ready && is_req) stat_full_cycles <= sat_inc(stat_full_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_mem_request_buffer.sv
// Self-checking bench for mem_request_buffer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_mem_request_buffer;
    localparam int DW = 32, AW = 32, MB = 4, DEPTH = 4, TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [MB-1:0] in_msg, mem_resp_msg;
    logic [AW-1:0] in_address, mem_resp_address;
    logic [DW-1:0] in_data, mem_resp_data;
    logic          in_ready, error;
    logic [MB-1:0] resp_msg, mem_msg;
    logic [AW-1:0] resp_address, mem_address;
    logic [DW-1:0] resp_data, mem_data;
`ifdef MEM_REQ_BUF_STATS_EN
    logic [31:0]   stat_reads, stat_writes, stat_full_cycles;
`endif

    always #5 clock = ~clock;

    mem_request_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MSG_BITS(MB),
                         .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .in_msg(in_msg), .in_address(in_address), .in_data(in_data), .in_ready(in_ready),
        .resp_msg(resp_msg), .resp_address(resp_address), .resp_data(resp_data),
        .mem_msg(mem_msg), .mem_address(mem_address), .mem_data(mem_data),
        .mem_resp_msg(mem_resp_msg), .mem_resp_address(mem_resp_address),
        .mem_resp_data(mem_resp_data), .error(error)
`ifdef MEM_REQ_BUF_STATS_EN
        , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_full_cycles(stat_full_cycles)
`endif
    );

    typedef struct packed {
        logic [MB-1:0] msg;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model: pending requests in arrival order plus the expected outputs.
    ent_t          mq[$];
    bit            m_busy, m_err;
    int            m_wait;
    logic [MB-1:0] e_mem_msg, e_resp_msg;
    logic [AW-1:0] e_mem_addr, e_resp_addr;
    logic [DW-1:0] e_mem_data, e_resp_data;
    logic          e_error;
    int            m_reads, m_writes, m_full;

    int checks = 0, failures = 0;
    logic [31:0] exp_order [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    function automatic void model_reset();
        mq.delete();
        m_busy = 0; m_err = 0; m_wait = 0;
        e_mem_msg = 0; e_mem_addr = 0; e_mem_data = 0;
        e_resp_msg = 0; e_resp_addr = 0; e_resp_data = 0;
        e_error = 0; m_reads = 0; m_writes = 0; m_full = 0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    function automatic void model_edge();
        bit rdy, isreq;
        int sz;
        ent_t e;
        rdy   = (mq.size() < DEPTH);
        isreq = (in_msg == 1) || (in_msg == 2);
        sz    = mq.size();
        e_resp_msg = 0;
        if (!rdy && isreq) m_full++;
        if (m_busy) begin
            if (mem_resp_msg == 3 && mem_resp_address == e_mem_addr) begin
                e_resp_msg  = 3;
                e_resp_addr = e_mem_addr;
                e_resp_data = (e_mem_msg == 1) ? mem_resp_data : e_mem_data;
                e_mem_msg   = 0;
                void'(mq.pop_front());
                m_busy = 0;
            end else if (m_wait + 1 == TO) begin
                e_error = 1; e_mem_msg = 0; m_busy = 0; m_err = 1;
            end else begin
                m_wait++;
            end
        end else if (!m_err && sz > 0) begin
            e_mem_msg  = mq[0].msg;
            e_mem_addr = mq[0].addr;
            e_mem_data = mq[0].data;
            m_busy = 1; m_wait = 0;
            if (mq[0].msg == 1) m_reads++; else m_writes++;
        end
        if (rdy && isreq) begin
            e.msg = in_msg; e.addr = in_address; e.data = in_data;
            mq.push_back(e);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic rdy;
        rdy = (mq.size() < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("mem_msg", 32'(mem_msg), 32'(e_mem_msg));
        chk("mem_address", mem_address, e_mem_addr);
        chk("mem_data", mem_data, e_mem_data);
        chk("resp_msg", 32'(resp_msg), 32'(e_resp_msg));
        chk("resp_address", resp_address, e_resp_addr);
        chk("resp_data", resp_data, e_resp_data);
        chk("error", 32'(error), 32'(e_error));
`ifdef MEM_REQ_BUF_STATS_EN
        chk("stat_reads", stat_reads, 32'(m_reads));
        chk("stat_writes", stat_writes, 32'(m_writes));
        chk("stat_full_cycles", stat_full_cycles, 32'(m_full));
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k;
        bit take;
        logic [31:0] d;

        model_reset();
        reset = 1'b0;
        in_msg = 0; in_address = 0; in_data = 0;
        mem_resp_msg = 0; mem_resp_address = 0; mem_resp_data = 0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_msg", 32'(mem_msg), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        check_outputs();
        @(negedge clock);
        reset = 1'b1;

        // Single read answered three cycles after issue.
        in_msg = 1; in_address = 32'h100; in_data = $urandom;
        tick();
        in_msg = 0;
        tick();
        chk("rd_issue_msg", 32'(mem_msg), 32'd1);
        chk("rd_issue_addr", mem_address, 32'h100);
        tick(); tick();
        mem_resp_msg = 3; mem_resp_address = 32'h100; mem_resp_data = 32'hDEADBEEF;
        tick();
        chk("rd_resp_msg", 32'(resp_msg), 32'd3);
        chk("rd_resp_data", resp_data, 32'hDEADBEEF);
        chk("rd_mem_msg_clear", 32'(mem_msg), 32'd0);
        mem_resp_msg = 0;
        tick();
        chk("rd_resp_one_cycle", 32'(resp_msg), 32'd0);

        // Fill with memory stalled, then release and check issue order.
        acc = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            in_msg = 2; in_address = 32'(acc * 4); in_data = $urandom;
            take = (mq.size() < DEPTH);
            tick();
            if (take) acc++;
        end
        chk("fill_full", 32'(in_ready), 32'd0);
        in_msg = 2; in_address = 32'h10; in_data = $urandom;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fill_held", 32'(in_ready), 32'd0);
        end
        k = 0;
        for (int c = 0; c < 60 && k < 5; c++) begin
            if (m_busy) begin
                chk("fill_order", mem_address, exp_order[k]);
                mem_resp_msg = 3; mem_resp_address = exp_order[k]; mem_resp_data = $urandom;
                k++;
            end else begin
                mem_resp_msg = 0;
            end
            take = (mq.size() < DEPTH) && (in_msg == 2);
            tick();
            if (take) in_msg = 0;
        end
        chk("fill_all_issued", 32'(k), 32'd5);
        mem_resp_msg = 0; in_msg = 0;
        tick();

        // Wrong-address response is ignored.
        in_msg = 1; in_address = 32'h20; in_data = $urandom;
        tick();
        in_msg = 0;
        tick();
        mem_resp_msg = 3; mem_resp_address = 32'h24; mem_resp_data = $urandom;
        tick();
        chk("wa_mem_msg_stable", 32'(mem_msg), 32'd1);
        chk("wa_mem_addr_stable", mem_address, 32'h20);
        chk("wa_no_resp", 32'(resp_msg), 32'd0);
        d = $urandom;
        mem_resp_address = 32'h20; mem_resp_data = d;
        tick();
        chk("wa_resp_msg", 32'(resp_msg), 32'd3);
        chk("wa_resp_addr", resp_address, 32'h20);
        chk("wa_resp_data", resp_data, d);
        mem_resp_msg = 0;
        tick();

        // Randomized traffic with a responder that always answers before the timeout.
        for (int c = 0; c < 800; c++) begin
            in_msg = 4'($urandom_range(0, 3));
            in_address = 32'($urandom_range(0, 63)) << 2;
            in_data = $urandom;
            if (m_busy && (m_wait >= 8 || $urandom_range(0, 2) == 0)) begin
                mem_resp_msg = 3; mem_resp_address = e_mem_addr;
            end else if (m_busy && $urandom_range(0, 3) == 0) begin
                mem_resp_msg = 3; mem_resp_address = e_mem_addr ^ 32'h4;
            end else begin
                mem_resp_msg = 4'($urandom_range(0, 2)); mem_resp_address = $urandom;
            end
            mem_resp_data = $urandom;
            tick();
        end
        in_msg = 0;
        for (int c = 0; c < 200 && (mq.size() > 0 || m_busy); c++) begin
            if (m_busy) begin
                mem_resp_msg = 3; mem_resp_address = e_mem_addr; mem_resp_data = $urandom;
            end else begin
                mem_resp_msg = 0;
            end
            tick();
        end
        mem_resp_msg = 0;
        tick();
        chk("drain_mem_msg", 32'(mem_msg), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);

        // Timeout: no response at all.
        in_msg = 1; in_address = 32'h80; in_data = $urandom;
        tick();
        in_msg = 0;
        tick();
        for (int n = 1; n <= TO; n++) begin
            tick();
            if (n < TO) chk("to_no_error_yet", 32'(error), 32'd0);
        end
        chk("to_error", 32'(error), 32'd1);
        chk("to_mem_msg", 32'(mem_msg), 32'd0);
        in_msg = 1; in_address = 32'h84; in_data = $urandom;
        for (int c = 0; c < 6; c++) tick();
        in_msg = 0;
        for (int c = 0; c < 6; c++) tick();
        chk("err_fifo_full", 32'(in_ready), 32'd0);
        chk("err_no_issue", 32'(mem_msg), 32'd0);
        chk("err_sticky", 32'(error), 32'd1);

        // Leave ERROR, then reset mid-WAIT with three entries queued.
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_clears_error", 32'(error), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_msg = 1; in_address = 32'h200 + 32'(i * 4); in_data = $urandom;
            tick();
        end
        in_msg = 0;
        tick(); tick();
        chk("mw_waiting", 32'(mem_msg), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("mw_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mw_rst_mem_msg", 32'(mem_msg), 32'd0);
        chk("mw_rst_mem_addr", mem_address, 32'd0);
        check_outputs();
        @(negedge clock);
        reset = 1'b1;
        mem_resp_msg = 3; mem_resp_address = 32'h200; mem_resp_data = $urandom;
        tick();
        chk("late_resp_ignored", 32'(resp_msg), 32'd0);
        mem_resp_msg = 0;
        in_msg = 1; in_address = 32'h40; in_data = $urandom;
        tick();
        in_msg = 0;
        tick();
        chk("post_rst_issue", mem_address, 32'h40);
        d = $urandom;
        mem_resp_msg = 3; mem_resp_address = 32'h40; mem_resp_data = d;
        tick();
        chk("post_rst_resp", resp_data, d);
        mem_resp_msg = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
